// File: rtl/kong_key_decoder.sv
// PS/2 scan-code decoder for Kong: held left/right levels, sticky start_game, throw pulse.
// Define KONG_KEY_WASD_EN to also accept plain A (1C) / D (23) as left / right.
module kong_key_decoder #(
  parameter logic [7:0] KEY_LEFT       = 8'h6B,
  parameter logic [7:0] KEY_RIGHT      = 8'h74,
  parameter logic [7:0] KEY_START      = 8'h5A,
  parameter logic [7:0] KEY_THROW      = 8'h29,
  parameter int         PREFIX_TIMEOUT = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       left,
  output logic       right,
  output logic       start_game,
  output logic       throw
);

`ifdef KONG_KEY_WASD_EN
  localparam bit WASD_EN = 1'b1;
`else
  localparam bit WASD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BREAK, ST_EXT_BREAK} state_t;

  state_t      state, state_n;
  logic [20:0] tmo_cnt;
  logic        tmo;
  logic        make_p, make_e, brk_p, brk_e;
  logic        held_l, held_r, held_t, last;
  logic        held_l_n, held_r_n, held_t_n, last_n, start_n;
  logic        l_make, l_brk, r_make, r_brk;

  assign tmo = (state != ST_IDLE) && !rx_valid && (tmo_cnt == 21'(PREFIX_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    make_p  = 1'b0;
    make_e  = 1'b0;
    brk_p   = 1'b0;
    brk_e   = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE:
          if (rx_data == 8'hE0)      state_n = ST_EXT;
          else if (rx_data == 8'hF0) state_n = ST_BREAK;
          else                       make_p  = 1'b1;
        ST_EXT:
          if (rx_data == 8'hE0)      state_n = ST_EXT;
          else if (rx_data == 8'hF0) state_n = ST_EXT_BREAK;
          else begin
            make_e  = 1'b1;
            state_n = ST_IDLE;
          end
        ST_BREAK: begin
          brk_p   = 1'b1;
          state_n = ST_IDLE;
        end
        default: begin
          brk_e   = 1'b1;
          state_n = ST_IDLE;
        end
      endcase
    end else if (tmo) begin
      // stale prefix: drop it without touching key state
      state_n = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                          tmo_cnt <= '0;
    else if (rx_valid || state == ST_IDLE) tmo_cnt <= '0;
    else                                 tmo_cnt <= tmo_cnt + 21'd1;
  end

  // Numpad (plain) 6B/74 are deliberately not treated as arrows.
  assign l_make = (make_e && rx_data == KEY_LEFT)  || (WASD_EN && make_p && rx_data == 8'h1C);
  assign l_brk  = (brk_e  && rx_data == KEY_LEFT)  || (WASD_EN && brk_p  && rx_data == 8'h1C);
  assign r_make = (make_e && rx_data == KEY_RIGHT) || (WASD_EN && make_p && rx_data == 8'h23);
  assign r_brk  = (brk_e  && rx_data == KEY_RIGHT) || (WASD_EN && brk_p  && rx_data == 8'h23);

  always_comb begin
    held_l_n = held_l;
    held_r_n = held_r;
    held_t_n = held_t;
    last_n   = last;
    start_n  = start_game;
    if (l_make) begin
      held_l_n = 1'b1;
      last_n   = 1'b0;
    end else if (l_brk) begin
      held_l_n = 1'b0;
    end
    if (r_make) begin
      held_r_n = 1'b1;
      last_n   = 1'b1;
    end else if (r_brk) begin
      held_r_n = 1'b0;
    end
    if (make_p && rx_data == KEY_THROW)     held_t_n = 1'b1;
    else if (brk_p && rx_data == KEY_THROW) held_t_n = 1'b0;
    if (make_p && rx_data == KEY_START)     start_n  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_l     <= 1'b0;
      held_r     <= 1'b0;
      held_t     <= 1'b0;
      last       <= 1'b0;
      start_game <= 1'b0;
      left       <= 1'b0;
      right      <= 1'b0;
      throw      <= 1'b0;
    end else begin
      held_l     <= held_l_n;
      held_r     <= held_r_n;
      held_t     <= held_t_n;
      last       <= last_n;
      start_game <= start_n;
      // last-pressed wins when both arrows are held
      left       <= start_n & held_l_n & (~held_r_n | ~last_n);
      right      <= start_n & held_r_n & (~held_l_n |  last_n);
      throw      <= start_game & make_p & (rx_data == KEY_THROW) & ~held_t;
    end
  end

endmodule
